// File: rtl/knn_ctrl_pkg.sv
// Shared state encoding and field layout for the k-NN sequencer.
package knn_ctrl_pkg;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_INIT  = 4'd1;
   localparam logic [3:0] S_FETCH = 4'd2;
   localparam logic [3:0] S_LOAD  = 4'd3;
   localparam logic [3:0] S_ACC_X = 4'd4;
   localparam logic [3:0] S_ACC_Y = 4'd5;
   localparam logic [3:0] S_REG   = 4'd6;
   localparam logic [3:0] S_PUSH  = 4'd7;
   localparam logic [3:0] S_DONE  = 4'd8;

   localparam int unsigned CYC_PER_PT = 6;

   localparam int unsigned X_MSB = 31;
   localparam int unsigned X_LSB = 16;
   localparam int unsigned Y_MSB = 15;
   localparam int unsigned Y_LSB = 0;

   // Cycles from an accepted go to the done pulse, inclusive of both ends' edges.
   function automatic int unsigned run_cycles(input int unsigned n);
      return 2 + CYC_PER_PT * n;
   endfunction

endpackage

// File: rtl/knn_ctrl_cnt.sv
// Loadable address / remaining-point counter pair with address wrap and count decode.
module knn_ctrl_cnt
   import knn_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   n_train,
   output logic [ADDR_W-1:0] addr,
   output logic              rem_zero,
   output logic              rem_one
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else if (load) begin
         addr_q <= base_addr;
         rem_q  <= n_train;
      end else if (step) begin
         // Address wraps naturally modulo 2^ADDR_W.
         addr_q <= addr_q + ADDR_W'(1);
         rem_q  <= rem_q - (ADDR_W + 1)'(1);
      end
   end

   assign addr     = addr_q;
   assign rem_zero = (rem_q == '0);
   assign rem_one  = (rem_q == (ADDR_W + 1)'(1));

endmodule

// File: rtl/knn_ctrl.sv
// k-NN sequencer: walks the training memory and strobes the distance/list datapath per point.
module knn_ctrl
   import knn_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LABEL  = 8,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   n_train,
   output logic              busy,
   output logic              done,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [LABEL-1:0]  lbl_rdata,
   output logic [DATA_W-1:0] core_b,
   output logic [LABEL-1:0]  core_label,
   output logic              core_start,
   output logic              core_rst_acc,
   output logic              core_en_acc,
   output logic              core_sel_xy,
   output logic              core_en_reg,
   output logic              core_valid
);

   logic [3:0] state_q, state_d;
   logic       cnt_load, cnt_step;
   logic       rem_zero, rem_one;

   assign cnt_load = (state_q == S_IDLE) && go && !abort;
   assign cnt_step = (state_q == S_PUSH);

   knn_ctrl_cnt #(
      .ADDR_W(ADDR_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .step     (cnt_step),
      .base_addr(base_addr),
      .n_train  (n_train),
      .addr     (mem_addr),
      .rem_zero (rem_zero),
      .rem_one  (rem_one)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cnt_load) state_d = S_INIT;
         S_INIT:  state_d = rem_zero ? S_DONE : S_FETCH;
         S_FETCH: state_d = S_LOAD;
         S_LOAD:  state_d = S_ACC_X;
         S_ACC_X: state_d = S_ACC_Y;
         S_ACC_Y: state_d = S_REG;
         S_REG:   state_d = S_PUSH;
         S_PUSH:  state_d = rem_one ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // Strobes are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         mem_ren      <= 1'b0;
         core_start   <= 1'b0;
         core_rst_acc <= 1'b0;
         core_en_acc  <= 1'b0;
         core_sel_xy  <= 1'b0;
         core_en_reg  <= 1'b0;
         core_valid   <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy         <= (state_d != S_IDLE);
         done         <= (state_d == S_DONE);
         mem_ren      <= (state_d == S_FETCH);
         core_start   <= (state_d == S_INIT);
         core_rst_acc <= (state_d == S_LOAD);
         core_en_acc  <= (state_d == S_ACC_X) || (state_d == S_ACC_Y);
         core_sel_xy  <= (state_d == S_ACC_Y);
         core_en_reg  <= (state_d == S_REG);
         core_valid   <= (state_d == S_PUSH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         core_b     <= '0;
         core_label <= '0;
      end else if (state_q == S_LOAD) begin
         core_b     <= {mem_rdata[X_MSB:X_LSB], mem_rdata[Y_MSB:Y_LSB]};
         core_label <= lbl_rdata;
      end
   end

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl: table of whole runs plus hand-written abort/reset/go sequences.
module tb_knn_ctrl;
   import knn_ctrl_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          go = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   n_train = '0;
   logic          busy, done, mem_ren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [LW-1:0] lbl_rdata = '0;
   logic [DW-1:0] core_b;
   logic [LW-1:0] core_label;
   logic          core_start, core_rst_acc, core_en_acc, core_sel_xy, core_en_reg, core_valid;

   knn_ctrl #(
      .DATA_W(DW),
      .LABEL (LW),
      .ADDR_W(AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go          (go),
      .abort       (abort),
      .base_addr   (base_addr),
      .n_train     (n_train),
      .busy        (busy),
      .done        (done),
      .mem_ren     (mem_ren),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .lbl_rdata   (lbl_rdata),
      .core_b      (core_b),
      .core_label  (core_label),
      .core_start  (core_start),
      .core_rst_acc(core_rst_acc),
      .core_en_acc (core_en_acc),
      .core_sel_xy (core_sel_xy),
      .core_en_reg (core_en_reg),
      .core_valid  (core_valid)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] pmem [0:1023];
   logic [LW-1:0] lmem [0:1023];

   always @(posedge clk) begin
      if (mem_ren) begin
         mem_rdata <= pmem[mem_addr];
         lbl_rdata <= lmem[mem_addr];
      end
   end

   // Event monitor, sampled on the falling edge.
   int            abs_cyc = 0;
   int            tot_start = 0, tot_done = 0, tot_valid = 0;
   int            start_stamp = 0, done_stamp = 0;
   logic [AW-1:0] addr_log [$];
   logic [LW-1:0] lbl_log [$];
   logic [DW-1:0] b_log [$];

   always @(negedge clk) begin
      abs_cyc++;
      if (core_start) begin
         tot_start++;
         start_stamp = abs_cyc;
      end
      if (mem_ren) addr_log.push_back(mem_addr);
      if (core_valid) begin
         tot_valid++;
         lbl_log.push_back(core_label);
         b_log.push_back(core_b);
      end
      if (done) begin
         tot_done++;
         done_stamp = abs_cyc;
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_out();
      return {busy, done, mem_ren, mem_addr, core_b, core_label, core_start, core_rst_acc,
              core_en_acc, core_sel_xy, core_en_reg, core_valid};
   endfunction

   function automatic logic [63:0] strobes();
      return {55'd0, busy, done, mem_ren, core_start, core_rst_acc, core_en_acc, core_sel_xy,
              core_en_reg, core_valid};
   endfunction

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   n;
      int            exp_done;
      logic [AW-1:0] exp_first;
      logic [AW-1:0] exp_last;
      logic [LW-1:0] exp_last_lbl;
   } vec_t;

   int g_cyc;

   task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] n);
      @(posedge clk); #1;
      base_addr = b;
      n_train   = n;
      go        = 1'b1;
      g_cyc     = abs_cyc + 1;
      @(posedge clk); #1;
      go        = 1'b0;
      base_addr = AW'($urandom);
      n_train   = (AW + 1)'($urandom);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int s0, d0, k, n;
      s0 = tot_start;
      d0 = tot_done;
      n  = int'(v.n);
      addr_log.delete();
      lbl_log.delete();
      b_log.delete();
      start_run(v.base, v.n);
      k = 0;
      while (tot_done == d0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({tag, " done_cycle"}, 64'(done_stamp - g_cyc), 64'(v.exp_done));
      check({tag, " done_count"}, 64'(tot_done - d0), 64'd1);
      check({tag, " start_count"}, 64'(tot_start - s0), 64'd1);
      check({tag, " start_cycle"}, 64'(start_stamp - g_cyc), 64'd1);
      check({tag, " ren_count"}, 64'(addr_log.size()), 64'(n));
      check({tag, " valid_count"}, 64'(lbl_log.size()), 64'(n));
      check({tag, " busy_after"}, 64'(busy), 64'd0);
      if (n > 0 && addr_log.size() == n && lbl_log.size() == n) begin
         check({tag, " first_addr"}, 64'(addr_log[0]), 64'(v.exp_first));
         check({tag, " last_addr"}, 64'(addr_log[n-1]), 64'(v.exp_last));
         check({tag, " last_label"}, 64'(lbl_log[n-1]), 64'(v.exp_last_lbl));
         for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = v.base + AW'(i);
            check({tag, " addr_seq"}, 64'(addr_log[i]), 64'(a));
            check({tag, " label_seq"}, 64'(lbl_log[i]), 64'(lmem[a]));
            check({tag, " core_b_seq"}, 64'(b_log[i]), 64'(pmem[a]));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [4];
      int   s0, d0, v0;

      for (int a = 0; a < 1024; a++) begin
         pmem[a] = {16'(a * 3), 16'(a * 5 + 1)};
         lmem[a] = 8'(a);
      end
      pmem[10'h010] = 32'h0005_0003; lmem[10'h010] = 8'd7;
      pmem[10'h011] = 32'h0001_0001; lmem[10'h011] = 8'd8;
      pmem[10'h012] = 32'h0002_0002; lmem[10'h012] = 8'd9;

      tbl[0] = '{10'h010, 11'd3, 20, 10'h010, 10'h012, 8'd9};
      tbl[1] = '{10'h000, 11'd0, 2, 10'h000, 10'h000, 8'd0};
      tbl[2] = '{10'h3FF, 11'd2, 14, 10'h3FF, 10'h000, 8'h00};
      tbl[3] = '{10'h100, 11'd1, 8, 10'h100, 10'h100, 8'h00};

      // Reset, then 10 idle cycles with go low.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", all_out(), 64'd0);
      end

      for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // abort together with go in IDLE: abort wins.
      s0 = tot_start;
      @(posedge clk); #1;
      go = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      go = 1'b0; abort = 1'b0;
      check("abort_go_idle_busy", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1 check("abort_go_idle_start", 64'(tot_start - s0), 64'd0);

      // abort in ACC_Y of the second point.
      d0 = tot_done;
      v0 = tot_valid;
      start_run(10'h020, 11'd4);
      repeat (10) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      check("abort_in_acc_y", 64'({core_en_acc, core_sel_xy}), 64'd3);
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_strobes", strobes(), 64'd0);
      repeat (30) @(posedge clk);
      #1;
      check("abort_no_done", 64'(tot_done - d0), 64'd0);
      check("abort_valid_count", 64'(tot_valid - v0), 64'd1);
      run_vec('{10'h020, 11'd1, 8, 10'h020, 10'h020, 8'h20}, "after_abort");

      // go while busy is neither honoured nor queued.
      s0 = tot_start;
      d0 = tot_done;
      start_run(10'h030, 11'd1);
      repeat (3) @(posedge clk);
      #1 go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("busy_go_start_count", 64'(tot_start - s0), 64'd1);
      check("busy_go_done_count", 64'(tot_done - d0), 64'd1);
      check("busy_go_idle", 64'(busy), 64'd0);

      // rst mid-run.
      d0 = tot_done;
      start_run(10'h040, 11'd2);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_outputs", all_out(), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("rst_no_done", 64'(tot_done - d0), 64'd0);
      check("rst_idle", 64'(busy), 64'd0);
      run_vec(tbl[0], "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
Sequencer for the k-NN datapath (distance unit plus sorted neighbour list). On a `go` pulse it walks `n_train` training points in a point/label memory and feeds each point and label to the datapath. It drives the accumulator and register enables, x/y select, list clear and list insert strobes, then reports `done`. It sits between the software-visible register block and the k-NN core.

Parameters:
DATA_W, 32, training point word width: {x[31:16], y[15:0]}
LABEL, 8, label width
ADDR_W, 10, point memory address width; `n_train` is ADDR_W+1 bits so 2^ADDR_W points fit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
go  in  1  start pulse; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE with no `done`
base_addr  in  ADDR_W  address of the first training point
n_train  in  ADDR_W+1  number of training points to process
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes
mem_ren  out  1  point/label memory read enable
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  point word; valid exactly 1 cycle after mem_ren
lbl_rdata  in  LABEL  label; same timing as mem_rdata
core_b  out  DATA_W  latched training point to the datapath B input
core_label  out  LABEL  latched label to the list
core_start  out  1  clears the neighbour list
core_rst_acc  out  1  clears the distance accumulator
core_en_acc  out  1  accumulate enable
core_sel_xy  out  1  0 = x component, 1 = y component
core_en_reg  out  1  distance output register enable
core_valid  out  1  inserts the candidate into the list

Behaviour:
- Reset: all outputs 0; state IDLE; point counter 0; core_b and core_label 0.
- All control outputs are registered Moore decodes of state; each strobe is high for exactly 1 cycle per listed state.
- IDLE: go=1 and abort=0 -> latch n_train into a remaining counter, latch base_addr into the address register, go to INIT.
- INIT: core_start=1 for 1 cycle. Next state is DONE if remaining==0, else FETCH.
- FETCH: mem_ren=1, mem_addr=current address -> LOAD.
- LOAD: capture mem_rdata into core_b and lbl_rdata into core_label; core_rst_acc=1 -> ACC_X.
- ACC_X: core_en_acc=1, core_sel_xy=0 -> ACC_Y.
- ACC_Y: core_en_acc=1, core_sel_xy=1 -> REG.
- REG: core_en_reg=1 -> PUSH.
- PUSH: core_valid=1; address+1 (wraps modulo 2^ADDR_W); remaining-1. Next state is DONE if remaining was 1, else FETCH.
- DONE: done=1, busy=1 -> IDLE.
- Latency: 6 cycles per point. go to done pulse is 1+6n+1 cycles (n=0: 2 cycles).
- core_b and core_label hold their value from LOAD until the next LOAD.
- go while busy: ignored and not queued.
- abort in any non-IDLE state: next cycle IDLE with all strobes 0; no done; list contents left as-is.
- abort and go together in IDLE: abort wins and the block stays IDLE.
- rst mid-run: identical to the reset state on the next edge; no done.
- base_addr and n_train are sampled only on an accepted go; later changes have no effect on the run.
- Address wrap: base_addr=2^ADDR_W-1 with n_train=2 reads the last address, then 0.

Decomposition:
- Package knn_ctrl_pkg holds:
  - state enum (IDLE, INIT, FETCH, LOAD, ACC_X, ACC_Y, REG, PUSH, DONE), 4-bit encoding;
  - constant CYC_PER_PT=6;
  - field slice constants X_MSB=31, X_LSB=16, Y_MSB=15, Y_LSB=0.
- One sub-module, knn_ctrl_cnt: the loadable address/remaining counter pair with wrap and zero-detect. The FSM stays in knn_ctrl.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; go held low -> busy=0, no strobes.
- n_train=3, base_addr=0x010, memory words 0x00050003/0x00010001/0x00020002 with labels 7/8/9 -> core_start once; mem_addr 0x010, 0x011, 0x012; core_valid 3 times with core_label 7, 8, 9; done exactly at cycle 20 after go.
- n_train=0 -> core_start at cycle 1, done at cycle 2, mem_ren never asserted.
- Wrap: base_addr=0x3FF, n_train=2 -> mem_addr 0x3FF then 0x000; done at cycle 14.
- abort asserted in ACC_Y of point 2 (n_train=4) -> IDLE next cycle, no done, no further core_valid. A new go then restarts from base_addr with core_start.
- go pulsed while busy, plus rst asserted mid-run -> no second run and no queued go. After rst, all outputs 0 and the next go runs a normal sequence.
